lcd_cmd_sequencer: RTL and testbench

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_sequencer
// Description : Power-up wait, HD44780 4-bit init list, then 2x16 frame
//               redraws from a 32-byte character buffer.
//               Each word is handed to a downstream nibble writer using a
//               start/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_sequencer #(
    parameter int POWERUP_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       refresh,
    input  logic       char_we,
    input  logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic [8:0] cmd_word,
    output logic       cmd_start,
    input  logic       cmd_ready,
    output logic       busy,
    output logic       init_done
);

    localparam logic [2:0]  c_POWERUP   = 3'd0;
    localparam logic [2:0]  c_ISSUE     = 3'd1;
    localparam logic [2:0]  c_WAIT_LOW  = 3'd2;
    localparam logic [2:0]  c_WAIT_HIGH = 3'd3;
    localparam logic [2:0]  c_NEXT      = 3'd4;
    localparam logic [2:0]  c_IDLE      = 3'd5;

    localparam logic [19:0] c_PU_LAST     = 20'(POWERUP_CYCLES - 1);
    localparam logic [2:0]  c_INIT_LAST   = 3'd5;
    localparam logic [5:0]  c_FRAME_LAST  = 6'd33;
    localparam logic [5:0]  c_LINE2_INDEX = 6'd17;

    logic [2:0]  r_state,     w_state_nxt;
    logic [19:0] r_cnt,       w_cnt_nxt;
    logic [2:0]  r_init_idx,  w_init_idx_nxt;
    logic [5:0]  r_frame_idx, w_frame_idx_nxt;
    logic        r_in_frame,  w_in_frame_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic        r_pending,   w_pending_nxt;
    logic [8:0]  r_cmd_word;
    logic        r_cmd_start;
    logic        r_busy;
    logic [7:0]  r_buf [0:31];

    logic [4:0]  w_rd_addr;
    logic [7:0]  w_char;
    logic [8:0]  w_entry;

    // Sequencer state and list position registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_POWERUP;
            r_cnt       <= 20'd0;
            r_init_idx  <= 3'd0;
            r_frame_idx <= 6'd0;
            r_in_frame  <= 1'b0;
            r_init_done <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_idx  <= w_init_idx_nxt;
            r_frame_idx <= w_frame_idx_nxt;
            r_in_frame  <= w_in_frame_nxt;
            r_init_done <= w_init_done_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    // Next-state, list advance and refresh bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_idx_nxt  = r_init_idx;
        w_frame_idx_nxt = r_frame_idx;
        w_in_frame_nxt  = r_in_frame;
        w_init_done_nxt = r_init_done;
        // Requests outside IDLE collapse into one pending redraw
        w_pending_nxt   = r_pending | (refresh & (r_state != c_IDLE));
        case (r_state)
            c_POWERUP: begin
                if (r_cnt == c_PU_LAST) begin
                    w_state_nxt    = c_ISSUE;
                    w_cnt_nxt      = 20'd0;
                    w_init_idx_nxt = 3'd0;
                    w_in_frame_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            c_ISSUE:     w_state_nxt = c_WAIT_LOW;
            c_WAIT_LOW:  if (!cmd_ready) w_state_nxt = c_WAIT_HIGH;
            c_WAIT_HIGH: if (cmd_ready)  w_state_nxt = c_NEXT;
            c_NEXT: begin
                w_state_nxt = c_ISSUE;
                if (!r_in_frame) begin
                    if (r_init_idx == c_INIT_LAST) begin
                        // Init finished: the first frame draw also serves any early refresh
                        w_init_done_nxt = 1'b1;
                        w_in_frame_nxt  = 1'b1;
                        w_frame_idx_nxt = 6'd0;
                        w_pending_nxt   = 1'b0;
                    end else begin
                        w_init_idx_nxt = r_init_idx + 3'd1;
                    end
                end else if (r_frame_idx == c_FRAME_LAST) begin
                    w_frame_idx_nxt = 6'd0;
                    w_pending_nxt   = 1'b0;
                    if (!(r_pending || refresh)) w_state_nxt = c_IDLE;
                end else begin
                    w_frame_idx_nxt = r_frame_idx + 6'd1;
                end
            end
            c_IDLE: begin
                if (refresh) begin
                    w_state_nxt     = c_ISSUE;
                    w_in_frame_nxt  = 1'b1;
                    w_frame_idx_nxt = 6'd0;
                end
            end
            default: w_state_nxt = c_POWERUP;
        endcase
    end

    // Buffer byte for the entry about to be issued; a write landing on the
    // same edge that enters ISSUE is forwarded so it is shown
    assign w_rd_addr = (w_frame_idx_nxt <= 6'd16) ? 5'(w_frame_idx_nxt - 6'd1)
                                                  : 5'(w_frame_idx_nxt - 6'd2);
    assign w_char    = (char_we && (char_addr == w_rd_addr)) ? char_data : r_buf[w_rd_addr];

    // List entry lookup for the next position
    always_comb begin
        w_entry = 9'h000;
        if (!w_in_frame_nxt) begin
            case (w_init_idx_nxt)
                3'd0:    w_entry = 9'h033;
                3'd1:    w_entry = 9'h032;
                3'd2:    w_entry = 9'h028;
                3'd3:    w_entry = 9'h00C;
                3'd4:    w_entry = 9'h006;
                default: w_entry = 9'h001;
            endcase
        end else if (w_frame_idx_nxt == 6'd0) begin
            w_entry = 9'h080;
        end else if (w_frame_idx_nxt == c_LINE2_INDEX) begin
            w_entry = 9'h0C0;
        end else begin
            w_entry = {1'b1, w_char};
        end
    end

    // Registered outputs, loaded on entry to ISSUE so they are valid in that cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd_word  <= 9'h000;
            r_cmd_start <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_cmd_start <= (w_state_nxt == c_ISSUE);
            r_busy      <= (w_state_nxt != c_IDLE);
            if (w_state_nxt == c_ISSUE) r_cmd_word <= w_entry;
        end
    end

    // Character buffer, writable in every state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else if (char_we) begin
            r_buf[char_addr] <= char_data;
        end
    end

    assign cmd_word  = r_cmd_word;
    assign cmd_start = r_cmd_start;
    assign busy      = r_busy;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cmd_sequencer
// Description : Scoreboard bench for lcd_cmd_sequencer with a nibble-writer
//               handshake model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_sequencer;

    localparam int c_PU     = 10;
    localparam int c_BUDGET = 3000;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       refresh   = 1'b0;
    logic       char_we   = 1'b0;
    logic [4:0] char_addr = 5'd0;
    logic [7:0] char_data = 8'd0;
    logic       cmd_ready = 1'b1;
    logic [8:0] cmd_word;
    logic       cmd_start;
    logic       busy;
    logic       init_done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;
    logic [7:0] m_buf [32];
    bit         stall_mode = 1'b0;
    int         wr_cnt = 0;

    lcd_cmd_sequencer #(.POWERUP_CYCLES(c_PU)) dut (
        .clock     (clock),
        .reset     (reset),
        .refresh   (refresh),
        .char_we   (char_we),
        .char_addr (char_addr),
        .char_data (char_data),
        .cmd_word  (cmd_word),
        .cmd_start (cmd_start),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    // Writer model: ready drops one cycle after start, returns 5 cycles later
    always @(negedge clock) begin
        if (!reset || stall_mode) begin
            cmd_ready = 1'b1;
            wr_cnt    = 0;
        end else if (cmd_start) begin
            wr_cnt = 1;
        end else if (wr_cnt != 0) begin
            if (wr_cnt == 1) cmd_ready = 1'b0;
            if (wr_cnt == 6) begin
                cmd_ready = 1'b1;
                wr_cnt    = 0;
            end else begin
                wr_cnt++;
            end
        end
    end

    // Scoreboard: every cmd_start must match the oldest expected word
    always @(negedge clock) begin
        if (cmd_start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_start: cmd_word=%h, required no cmd_start", cmd_word);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cmd_word !== mon_exp) begin
                    n_errors++;
                    $display("FAIL cmd_word: got %h, required %h", cmd_word, mon_exp);
                end
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h033); exp_q.push_back(9'h032); exp_q.push_back(9'h028);
        exp_q.push_back(9'h00C); exp_q.push_back(9'h006); exp_q.push_back(9'h001);
    endtask

    task automatic push_frame();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, m_buf[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, m_buf[i]});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        char_we = 1'b1; char_addr = a; char_data = d;
        @(negedge clock);
        char_we = 1'b0;
        m_buf[a] = d;
    endtask

    task automatic pulse_refresh();
        @(negedge clock);
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < c_BUDGET) begin
            @(negedge clock);
            k++;
        end
        ok = (busy === 1'b0) && (exp_q.size() == 0);
    endtask

    // Counts cmd_start pulses (including one already visible) until n have been seen
    task automatic wait_starts(input int n, output bit ok);
        int seen = cmd_start ? 1 : 0;
        int k = 0;
        while (seen < n && k < c_BUDGET) begin
            @(negedge clock);
            k++;
            if (cmd_start) seen++;
        end
        ok = (seen == n);
    endtask

    task automatic test_reset();
        bit early = 1'b0;
        reset_model();
        exp_q.delete();
        reset = 1'b0;
        tick(2);
        n_checks += 4;
        if (cmd_word !== 9'h000) begin n_errors++; $display("FAIL reset_cmd_word: got %h, required 000", cmd_word); end
        if (cmd_start !== 1'b0)  begin n_errors++; $display("FAIL reset_cmd_start: got %b, required 0", cmd_start); end
        if (busy !== 1'b1)       begin n_errors++; $display("FAIL reset_busy: got %b, required 1", busy); end
        if (init_done !== 1'b0)  begin n_errors++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
        push_init();
        push_frame();
        reset = 1'b1;
        repeat (c_PU - 1) begin
            @(negedge clock);
            if (cmd_start !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) begin n_errors++; $display("FAIL powerup_early_start: got start before %0d cycles, required none", c_PU); end
        @(negedge clock);
        n_checks++;
        if (cmd_start !== 1'b1) begin n_errors++; $display("FAIL powerup_latency: cmd_start=%b, required 1", cmd_start); end
    endtask

    task automatic test_init_and_first_frame();
        bit ok;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL init_frame_done: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
        if (init_done !== 1'b1) begin n_errors++; $display("FAIL init_done: got %b, required 1", init_done); end
        tick(20);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_stays: busy=%b, required 0", busy); end
    endtask

    task automatic test_chars();
        bit ok;
        write_char(5'd0, 8'h48);
        write_char(5'd17, 8'h69);
        push_frame();
        pulse_refresh();
        n_checks++;
        if (cmd_start !== 1'b1) begin n_errors++; $display("FAIL idle_refresh_latency: cmd_start=%b, required 1", cmd_start); end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL chars_frame: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
    endtask

    task automatic test_refresh_collapse();
        bit ok;
        push_frame();
        pulse_refresh();
        tick(30);
        push_frame();
        pulse_refresh();
        tick(40);
        pulse_refresh();
        tick(40);
        pulse_refresh();
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL collapse_frames: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
        tick(40);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL collapse_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_write_race();
        bit ok;
        push_frame();
        pulse_refresh();
        wait_starts(7, ok);
        // Same cycle as ISSUE of frame index 6 (buffer byte 5)
        char_we = 1'b1; char_addr = 5'd5; char_data = 8'h35;
        @(negedge clock);
        char_we = 1'b0;
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL race_sync: index 6 issue not reached, required reached"); end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL race_old_frame: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
        m_buf[5] = 8'h35;
        push_frame();
        pulse_refresh();
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL race_new_frame: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        stall_mode = 1'b1;
        exp_q.push_back(9'h080);
        pulse_refresh();
        tick(60);
        n_checks += 2;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL stall_busy: got %b, required 1", busy); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL stall_first_word: left=%0d, required 0", exp_q.size()); end
        // Recover by reset while the handshake is stuck
        reset = 1'b0;
        stall_mode = 1'b0;
        #1;
        n_checks += 3;
        if (cmd_word !== 9'h000) begin n_errors++; $display("FAIL stall_reset_word: got %h, required 000", cmd_word); end
        if (busy !== 1'b1)       begin n_errors++; $display("FAIL stall_reset_busy: got %b, required 1", busy); end
        if (init_done !== 1'b0)  begin n_errors++; $display("FAIL stall_reset_init_done: got %b, required 0", init_done); end
        reset_model();
        tick(2);
        push_init();
        push_frame();
        reset = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL stall_replay: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        write_char(5'd3, 8'h5A);
        push_frame();
        pulse_refresh();
        wait_starts(11, ok);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks += 5;
        if (!ok) begin n_errors++; $display("FAIL mid_sync: index 10 issue not reached, required reached"); end
        if (cmd_word !== 9'h000) begin n_errors++; $display("FAIL mid_reset_word: got %h, required 000", cmd_word); end
        if (cmd_start !== 1'b0)  begin n_errors++; $display("FAIL mid_reset_start: got %b, required 0", cmd_start); end
        if (busy !== 1'b1)       begin n_errors++; $display("FAIL mid_reset_busy: got %b, required 1", busy); end
        if (init_done !== 1'b0)  begin n_errors++; $display("FAIL mid_reset_init_done: got %b, required 0", init_done); end
        exp_q.delete();
        reset_model();
        tick(2);
        push_init();
        push_frame();
        reset = 1'b1;
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL mid_replay: busy=%b left=%0d, required 0 and 0", busy, exp_q.size()); end
        if (init_done !== 1'b1) begin n_errors++; $display("FAIL mid_init_done: got %b, required 1", init_done); end
    endtask

    initial begin
        test_reset();
        test_init_and_first_frame();
        test_chars();
        test_refresh_collapse();
        test_write_race();
        test_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
